// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

   localparam int WORD_W              = 32;
   localparam int DEFAULT_ADDR_W      = 9;
   localparam int DEFAULT_WAIT_CYCLES = 2;
   localparam int CNT_W               = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Datapath <-> memory responder bus. mem_err exists only when MEM_BOUNDS_EN is defined.
interface mem_responder_if;
   import mem_pkg::*;

   logic              Read;
   logic              Write;
   logic [WORD_W-1:0] MAR_data_out;
   logic [WORD_W-1:0] MDR_data_out;
   logic [WORD_W-1:0] Mdatain;
   logic              mem_done;
   logic              mem_busy;
`ifdef MEM_BOUNDS_EN
   logic              mem_err;

   modport master (output Read, Write, MAR_data_out, MDR_data_out,
                   input  Mdatain, mem_done, mem_busy, mem_err);
   modport slave  (input  Read, Write, MAR_data_out, MDR_data_out,
                   output Mdatain, mem_done, mem_busy, mem_err);
`else
   modport master (output Read, Write, MAR_data_out, MDR_data_out,
                   input  Mdatain, mem_done, mem_busy);
   modport slave  (input  Read, Write, MAR_data_out, MDR_data_out,
                   output Mdatain, mem_done, mem_busy);
`endif

endinterface

// File: rtl/mem_responder_sync_ram.sv
// Single-port synchronous RAM (read-first), one registered read port.
module sync_ram #(
   parameter int ADDR_W = 9,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

   // NOTE: the array has no reset; clearing it would forbid mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fixed-latency read/write of word-addressed RAM.
// Optional MEM_BOUNDS_EN adds out-of-range detection and the mem_err flag.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input logic            clk,
   input logic            clr,
   mem_responder_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_t            state, state_next;
   logic [CNT_W-1:0]  count;
   logic [WORD_W-1:0] mar_q, mdr_q, mdatain_q;
   logic              is_read_q;
   logic              accept, out_of_range;
   logic [WORD_W-1:0] ram_rdata, read_word;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;

   assign accept = (state == IDLE) && (bus.Read || bus.Write);

`ifdef MEM_BOUNDS_EN
   assign out_of_range = |mar_q[WORD_W-1:ADDR_W];
`else
   logic unused_upper;
   assign out_of_range = 1'b0;
   assign unused_upper = |mar_q[WORD_W-1:ADDR_W];
`endif

   assign read_word = out_of_range ? '0 : ram_rdata;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.Read || bus.Write)
                     state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT:    if (count == '0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_busy = (state != IDLE);
      bus.mem_done = (state == RESP);
`ifdef MEM_BOUNDS_EN
      bus.mem_err  = (state == RESP) && out_of_range;
`endif
      bus.Mdatain  = ((state == RESP) && is_read_q) ? read_word : mdatain_q;
      ram_we       = (state == RESP) && !is_read_q && !out_of_range;
      // In IDLE the RAM already reads the live address so a zero-wait read has data in RESP.
      ram_addr     = (state == IDLE) ? bus.MAR_data_out[ADDR_W-1:0] : mar_q[ADDR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         count     <= '0;
         mdatain_q <= '0;
      end else begin
         if (accept)                          count <= CNT_LOAD;
         else if (state == WAIT && count != 0) count <= count - CNT_W'(1);
         if (state == RESP && is_read_q)      mdatain_q <= read_word;
      end
   end

   // Read takes priority when both requests are high.
   always_ff @(posedge clk) begin
      if (accept) begin
         mar_q     <= bus.MAR_data_out;
         mdr_q     <= bus.MDR_data_out;
         is_read_q <= bus.Read;
      end
   end

   sync_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (mdr_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: channel a uses WAIT_CYCLES=2, channel b uses WAIT_CYCLES=0.
module tb_mem_responder;

`ifdef MEM_BOUNDS_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif
   localparam int WC_A = 2;
   localparam int WC_B = 0;

   typedef struct {
      string       tag;
      int          done_cyc;
      logic [31:0] data;
      bit          err;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t        qa[$], qb[$];
   logic [31:0] model_a [int];
   logic [31:0] model_b [int];
   logic [31:0] exp_md_a = '0;
   logic [31:0] exp_md_b = '0;

   mem_responder_if a_if ();
   mem_responder_if b_if ();

   mem_responder #(.ADDR_W(9), .WAIT_CYCLES(WC_A)) dut_a (.clk(clk), .clr(clr), .bus(a_if));
   mem_responder #(.ADDR_W(9), .WAIT_CYCLES(WC_B)) dut_b (.clk(clk), .clr(clr), .bus(b_if));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (a_if.mem_done) begin
         if (qa.size() == 0) check("a_spurious_done", 32'd1, 32'd0);
         else begin
            e = qa.pop_front();
            check({e.tag, "_cyc"}, 32'(cyc), 32'(e.done_cyc));
            check({e.tag, "_data"}, a_if.Mdatain, e.data);
`ifdef MEM_BOUNDS_EN
            check({e.tag, "_err"}, 32'(a_if.mem_err), 32'(e.err));
`endif
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (b_if.mem_done) begin
         if (qb.size() == 0) check("b_spurious_done", 32'd1, 32'd0);
         else begin
            e = qb.pop_front();
            check({e.tag, "_cyc"}, 32'(cyc), 32'(e.done_cyc));
            check({e.tag, "_data"}, b_if.Mdatain, e.data);
         end
      end
   end

   // Drive one request at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input bit ch, input bit rd, input bit wr, input logic [31:0] mar,
                        input logic [31:0] mdr, input string tag, input bit expect_done = 1'b1);
      exp_t e;
      bit   oor;
      int   ad;
      @(negedge clk);
      ad  = int'(mar[8:0]);
      oor = BOUNDS && (mar[31:9] != 0);
      if (expect_done) begin
         if (ch == 0) begin
            if (rd) exp_md_a = oor ? 32'h0 : model_a[ad];
            else if (!oor) model_a[ad] = mdr;
            e.data = exp_md_a;
         end else begin
            if (rd) exp_md_b = oor ? 32'h0 : model_b[ad];
            else if (!oor) model_b[ad] = mdr;
            e.data = exp_md_b;
         end
         e.tag      = tag;
         e.done_cyc = cyc + 1 + ((ch == 0) ? WC_A : WC_B);
         e.err      = oor;
         if (ch == 0) qa.push_back(e);
         else         qb.push_back(e);
      end
      if (ch == 0) begin
         a_if.Read = rd; a_if.Write = wr; a_if.MAR_data_out = mar; a_if.MDR_data_out = mdr;
      end else begin
         b_if.Read = rd; b_if.Write = wr; b_if.MAR_data_out = mar; b_if.MDR_data_out = mdr;
      end
      @(negedge clk);
      // Scramble bus inputs after accept: captured values must be used.
      if (ch == 0) begin
         a_if.Read = 1'b0; a_if.Write = 1'b0;
         a_if.MAR_data_out = $urandom; a_if.MDR_data_out = $urandom;
         check({tag, "_busy"}, 32'(a_if.mem_busy), 32'd1);
      end else begin
         b_if.Read = 1'b0; b_if.Write = 1'b0;
         b_if.MAR_data_out = $urandom; b_if.MDR_data_out = $urandom;
         check({tag, "_busy"}, 32'(b_if.mem_busy), 32'd1);
      end
   endtask

   task automatic drain(input bit ch, input string tag);
      for (int i = 0; i < 40 && ((ch == 0) ? qa.size() : qb.size()) != 0; i++) @(negedge clk);
      if (ch == 0) begin
         if (qa.size() != 0) begin check({tag, "_timeout"}, 32'(qa.size()), 32'd0); qa.delete(); end
         @(negedge clk);
         check({tag, "_hold"}, a_if.Mdatain, exp_md_a);
      end else begin
         if (qb.size() != 0) begin check({tag, "_timeout"}, 32'(qb.size()), 32'd0); qb.delete(); end
         @(negedge clk);
         check({tag, "_hold"}, b_if.Mdatain, exp_md_b);
      end
   endtask

   task automatic op(input bit ch, input bit rd, input bit wr, input logic [31:0] mar,
                     input logic [31:0] mdr, input string tag);
      issue(ch, rd, wr, mar, mdr, tag);
      drain(ch, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] mar;
      a_if.Read = 1'b0; a_if.Write = 1'b0; a_if.MAR_data_out = '0; a_if.MDR_data_out = '0;
      b_if.Read = 1'b0; b_if.Write = 1'b0; b_if.MAR_data_out = '0; b_if.MDR_data_out = '0;

      repeat (3) @(negedge clk);
      check("rst_a_md",   a_if.Mdatain, 32'h0);
      check("rst_a_done", 32'(a_if.mem_done), 32'd0);
      check("rst_a_busy", 32'(a_if.mem_busy), 32'd0);
      check("rst_b_md",   b_if.Mdatain, 32'h0);
      check("rst_b_busy", 32'(b_if.mem_busy), 32'd0);
`ifdef MEM_BOUNDS_EN
      check("rst_a_err",  32'(a_if.mem_err), 32'd0);
`endif
      clr = 1'b0;

      op(0, 0, 1, 32'h5, 32'hDEADBEEF, "wr5");
      op(0, 1, 0, 32'h5, 32'h0,        "rd5");
      op(0, 0, 1, 32'h6, 32'h11111111, "wr6");
      op(0, 0, 1, 32'h7, 32'h22222222, "wr7");

      op(0, 1, 1, 32'h5, 32'h12345678, "rdwr5");
      op(0, 1, 0, 32'h5, 32'h0,        "rd5_again");

      // Write asserted during WAIT must be ignored.
      issue(0, 1, 0, 32'h5, 32'h0, "rd5_ign");
      a_if.Write = 1'b1; a_if.MAR_data_out = 32'h6; a_if.MDR_data_out = 32'h0BADBAD0;
      @(negedge clk);
      check("ign_busy1", 32'(a_if.mem_busy), 32'd1);
      @(negedge clk);
      check("ign_busy2", 32'(a_if.mem_busy), 32'd1);
      a_if.Write = 1'b0;
      drain(0, "rd5_ign");
      op(0, 1, 0, 32'h6, 32'h0, "rd6_after_ign");

      // clr during WAIT drops the write and clears Mdatain.
      issue(0, 0, 1, 32'h7, 32'hCAFEF00D, "wr7_clr", 1'b0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_md_a = '0;
      exp_md_b = '0;
      for (int i = 0; i < 4; i++) begin
         check("clr_busy", 32'(a_if.mem_busy), 32'd0);
         check("clr_md",   a_if.Mdatain, 32'h0);
         @(negedge clk);
      end
      op(0, 1, 0, 32'h7, 32'h0, "rd7_after_clr");

      op(0, 0, 1, 32'h205, 32'hAAAA5555, "wr205");
      op(0, 1, 0, 32'h205, 32'h0,        "rd205");
      op(0, 1, 0, 32'h5,   32'h0,        "rd5_wrap");

      for (int a = 8; a < 16; a++) op(0, 0, 1, 32'(a), $urandom, "init");
      for (int i = 0; i < 16; i++) begin
         n   = $urandom_range(8, 15);
         mar = 32'(n);
         if ($urandom_range(0, 3) == 0) mar[31:9] = 23'($urandom);
         op(0, $urandom_range(0, 1) == 1, 1'b1, mar, $urandom, "rand");
      end

      // Zero-wait instance: back-to-back reads with Read held high.
      op(1, 0, 1, 32'h5, 32'h5A5A0001, "b_wr5");
      @(negedge clk);
      b_if.Read = 1'b1; b_if.MAR_data_out = 32'h5;
      exp_md_b = model_b[5];
      qb.push_back('{tag: "b_rd5_1", done_cyc: cyc + 1, data: exp_md_b, err: 1'b0});
      qb.push_back('{tag: "b_rd5_2", done_cyc: cyc + 3, data: exp_md_b, err: 1'b0});
      @(negedge clk);
      @(negedge clk);
      check("b_gap_busy", 32'(b_if.mem_busy), 32'd0);
      @(negedge clk);
      check("b_rd5_2_busy", 32'(b_if.mem_busy), 32'd1);
      b_if.Read = 1'b0;
      drain(1, "b_b2b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
